// File: rtl/c_elem_sync_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | c_elem_sync_array : clocked multi-channel C-element with input     |
// |   synchronizers, threshold mode, masking, event count, stuck flag   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module c_elem_sync_array #(
  parameter int IN_NUM      = 2,
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SET_TH      = 2,
  parameter int CLR_TH      = 0,
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     mode,
  input  logic [IN_NUM-1:0]        mask,
  input  logic [CH_NUM*IN_NUM-1:0] in,
  output logic [CH_NUM-1:0]        out,
  output logic [CH_NUM-1:0]        toggle,
  output logic [CNT_W-1:0]         evt_cnt,
  output logic [CH_NUM-1:0]        stuck
);

  localparam int CW    = $clog2(IN_NUM + 1);
  localparam int SUM_W = CNT_W + $clog2(CH_NUM + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [SUM_W-1:0] EVT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [CH_NUM*IN_NUM-1:0] sync_q [SYNC_STAGES];
  logic [CH_NUM*IN_NUM-1:0] sync_d [SYNC_STAGES];
  logic [CH_NUM-1:0]        out_q, out_d;
  logic [CH_NUM-1:0]        toggle_q, toggle_d;
  logic [CH_NUM-1:0]        stuck_q, stuck_d;
  logic [CNT_W-1:0]         evt_cnt_q, evt_cnt_d;
  logic [TO_W-1:0]          timer_q [CH_NUM];
  logic [TO_W-1:0]          timer_d [CH_NUM];
  logic [SUM_W-1:0]         evt_sum;
  logic [CH_NUM-1:0]        set_c, clr_c;
  logic                     u_empty;

  assign u_empty = &mask;

  always_comb begin
    sync_d[0] = in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [IN_NUM-1:0] raw_bits;
    logic [IN_NUM-1:0] u_bits;
    logic [CW-1:0]     ones;
    logic              set_w, clr_w;

    always_comb begin
      raw_bits = sync_q[SYNC_STAGES-1][c*IN_NUM +: IN_NUM];
      u_bits   = raw_bits & ~mask;
      ones     = '0;
      for (int b = 0; b < IN_NUM; b++) begin
        ones = ones + CW'(u_bits[b]);
      end
      set_w = 1'b0;
      clr_w = 1'b0;
      if (!u_empty) begin
        if (mode) begin
          set_w = (int'(ones) >= SET_TH);
          clr_w = (int'(ones) <= CLR_TH);
        end else begin
          // masked bits read as 1 for the all-ones test, as 0 for all-zeros
          set_w = &(raw_bits | mask);
          clr_w = ~|u_bits;
        end
      end
    end

    assign set_c[c] = set_w;
    assign clr_c[c] = clr_w;
  end

  always_comb begin
    out_d     = out_q;
    toggle_d  = '0;
    stuck_d   = '0;
    evt_cnt_d = evt_cnt_q;
    timer_d   = timer_q;
    for (int c = 0; c < CH_NUM; c++) begin
      if (!out_q[c] && set_c[c]) begin
        out_d[c] = 1'b1;
      end else if (out_q[c] && clr_c[c]) begin
        out_d[c] = 1'b0;
      end
    end
    if (clr) begin
      out_d = '0;
    end else begin
      toggle_d = out_d ^ out_q;
    end

    // a channel counts as held while its inputs disagree and no edge occurs
    for (int c = 0; c < CH_NUM; c++) begin
      if (clr || toggle_d[c] || u_empty || set_c[c] || clr_c[c]) begin
        timer_d[c] = '0;
      end else if (timer_q[c] < TO_MAX) begin
        timer_d[c] = timer_q[c] + 1'b1;
      end
      stuck_d[c] = (timer_d[c] == TO_MAX);
    end

    evt_sum = SUM_W'(evt_cnt_q) + SUM_W'($countones(toggle_d));
    if (clr) begin
      evt_cnt_d = '0;
    end else if (evt_sum > EVT_MAX) begin
      evt_cnt_d = '1;
    end else begin
      evt_cnt_d = evt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int c = 0; c < CH_NUM; c++) begin
        timer_q[c] <= '0;
      end
      out_q     <= '0;
      toggle_q  <= '0;
      stuck_q   <= '0;
      evt_cnt_q <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int c = 0; c < CH_NUM; c++) begin
        timer_q[c] <= timer_d[c];
      end
      out_q     <= out_d;
      toggle_q  <= toggle_d;
      stuck_q   <= stuck_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign out     = out_q;
  assign toggle  = toggle_q;
  assign stuck   = stuck_q;
  assign evt_cnt = evt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_c_elem_sync_array.sv
`default_nettype none
// tb_c_elem_sync_array : table-driven vectors with a cycle scoreboard model,
// plus hand sequences for asynchronous reset and post-reset latency.
module tb_c_elem_sync_array;

  localparam int IN      = 3;
  localparam int CH      = 4;
  localparam int SYN     = 2;
  localparam int SET_TH  = 2;
  localparam int CLR_TH  = 0;
  localparam int CNT_W   = 2;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 4;
  localparam int EVT_MAX = (1 << CNT_W) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr   = 1'b0;
  logic             mode  = 1'b0;
  logic [IN-1:0]    mask  = '0;
  logic [CH*IN-1:0] in_v  = '0;
  logic [CH-1:0]    out, toggle, stuck;
  logic [CNT_W-1:0] evt_cnt;

  always #5 clk = ~clk;

  c_elem_sync_array #(
    .IN_NUM(IN), .CH_NUM(CH), .SYNC_STAGES(SYN), .SET_TH(SET_TH), .CLR_TH(CLR_TH),
    .CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .mask(mask), .in(in_v),
    .out(out), .toggle(toggle), .evt_cnt(evt_cnt), .stuck(stuck)
  );

  typedef struct packed {
    logic [CH-1:0]    o;
    logic [CH-1:0]    t;
    logic [CNT_W-1:0] e;
    logic [CH-1:0]    s;
  } obs_t;

  typedef struct {
    logic             c;
    logic             md;
    logic [IN-1:0]    mk;
    logic [CH*IN-1:0] iv;
    int               cyc;
    logic [CH-1:0]    eo;
    logic [CNT_W-1:0] ee;
    logic [CH-1:0]    es;
  } vec_t;

  obs_t             exp_q[$];
  int               n_chk  = 0;
  int               n_pass = 0;

  logic [CH*IN-1:0] m_sync [SYN];
  logic [CH-1:0]    m_out;
  int               m_evt;
  int               m_timer [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < SYN; s++) m_sync[s] = '0;
    for (int c = 0; c < CH; c++) m_timer[c] = 0;
    m_out = '0;
    m_evt = 0;
  endtask

  // Behavioural reference: evaluates the last synchronizer stage, then shifts.
  task automatic model_step(input logic c, input logic md, input logic [IN-1:0] mk,
                            input logic [CH*IN-1:0] iv);
    logic [CH-1:0] nout, ntog, nstuck;
    logic [IN-1:0] v;
    logic          st, cl;
    int            n, nu;
    obs_t          e;
    for (int ch = 0; ch < CH; ch++) begin
      v  = m_sync[SYN-1][ch*IN +: IN];
      n  = 0;
      nu = 0;
      for (int b = 0; b < IN; b++) begin
        if (!mk[b]) begin
          nu++;
          if (v[b]) n++;
        end
      end
      if (nu == 0)  begin st = 1'b0;         cl = 1'b0;         end
      else if (md)  begin st = (n >= SET_TH); cl = (n <= CLR_TH); end
      else          begin st = (n == nu);     cl = (n == 0);      end
      nout[ch] = m_out[ch];
      if (!m_out[ch] && st)     nout[ch] = 1'b1;
      else if (m_out[ch] && cl) nout[ch] = 1'b0;
      if (c) nout[ch] = 1'b0;
      ntog[ch] = c ? 1'b0 : (nout[ch] ^ m_out[ch]);
      if (c || ntog[ch] || nu == 0 || st || cl) m_timer[ch] = 0;
      else if (m_timer[ch] < TIMEOUT)           m_timer[ch]++;
      nstuck[ch] = (m_timer[ch] == TIMEOUT);
    end
    m_evt = c ? 0 : m_evt + $countones(ntog);
    if (m_evt > EVT_MAX) m_evt = EVT_MAX;
    m_out = nout;
    for (int s = SYN - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = iv;
    e = {nout, ntog, CNT_W'(m_evt), nstuck};
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic c, input logic md, input logic [IN-1:0] mk,
                      input logic [CH*IN-1:0] iv, input string tag);
    obs_t a, e;
    clr  = c;
    mode = md;
    mask = mk;
    in_v = iv;
    model_step(c, md, mk, iv);
    @(posedge clk);
    #1;
    a = {out, toggle, evt_cnt, stuck};
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty, got %h", tag, a);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(a), 32'(e));
    end
  endtask

  vec_t tbl [20];

  initial begin
    //            clr md  mask    in       cyc out   evt   stuck
    tbl[0]  = '{1'b0, 1'b0, 3'b000, 12'h000, 3, 4'h0, 2'd0, 4'h0};
    tbl[1]  = '{1'b0, 1'b0, 3'b000, 12'h007, 3, 4'h1, 2'd1, 4'h0};
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 12'h003, 3, 4'h1, 2'd1, 4'h0};
    tbl[3]  = '{1'b0, 1'b0, 3'b000, 12'h000, 3, 4'h0, 2'd2, 4'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'b000, 12'h000, 1, 4'h0, 2'd0, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 3'b000, 12'h003, 3, 4'h1, 2'd1, 4'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'b000, 12'h001, 3, 4'h1, 2'd1, 4'h0};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 12'h000, 3, 4'h0, 2'd2, 4'h0};
    tbl[8]  = '{1'b0, 1'b0, 3'b110, 12'h001, 3, 4'h1, 2'd3, 4'h0};
    tbl[9]  = '{1'b0, 1'b0, 3'b111, 12'h000, 3, 4'h1, 2'd3, 4'h0};
    tbl[10] = '{1'b1, 1'b0, 3'b000, 12'h000, 1, 4'h0, 2'd0, 4'h0};
    tbl[11] = '{1'b0, 1'b0, 3'b000, 12'h007, 3, 4'h1, 2'd1, 4'h0};
    tbl[12] = '{1'b0, 1'b0, 3'b000, 12'h000, 3, 4'h0, 2'd2, 4'h0};
    tbl[13] = '{1'b0, 1'b0, 3'b000, 12'hFFF, 3, 4'hF, 2'd3, 4'h0};
    tbl[14] = '{1'b0, 1'b0, 3'b000, 12'h000, 3, 4'h0, 2'd3, 4'h0};
    tbl[15] = '{1'b1, 1'b0, 3'b000, 12'hFFF, 3, 4'h0, 2'd0, 4'h0};
    tbl[16] = '{1'b0, 1'b0, 3'b000, 12'hFFF, 1, 4'hF, 2'd3, 4'h0};
    tbl[17] = '{1'b1, 1'b0, 3'b000, 12'h000, 3, 4'h0, 2'd0, 4'h0};
    tbl[18] = '{1'b0, 1'b0, 3'b000, 12'h010, 6, 4'h0, 2'd0, 4'h2};
    tbl[19] = '{1'b0, 1'b0, 3'b000, 12'h038, 3, 4'h2, 2'd1, 4'h0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out",    32'(out),     32'(0));
    check("reset toggle", 32'(toggle),  32'(0));
    check("reset evt",    32'(evt_cnt), 32'(0));
    check("reset stuck",  32'(stuck),   32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < tbl[i].cyc; k++) begin
        tick(tbl[i].c, tbl[i].md, tbl[i].mk, tbl[i].iv, $sformatf("row%0d cyc%0d", i, k));
      end
      check($sformatf("row%0d out", i),   32'(out),     32'(tbl[i].eo));
      check($sformatf("row%0d evt", i),   32'(evt_cnt), 32'(tbl[i].ee));
      check($sformatf("row%0d stuck", i), 32'(stuck),   32'(tbl[i].es));
    end

    // asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst out",    32'(out),     32'(0));
    check("async_rst toggle", 32'(toggle),  32'(0));
    check("async_rst evt",    32'(evt_cnt), 32'(0));
    check("async_rst stuck",  32'(stuck),   32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first change after release needs full synchronizer latency
    tick(1'b0, 1'b0, 3'b000, 12'h007, "post_rst0");
    tick(1'b0, 1'b0, 3'b000, 12'h007, "post_rst1");
    check("latency_early out", 32'(out), 32'(0));
    tick(1'b0, 1'b0, 3'b000, 12'h007, "post_rst2");
    check("latency out",    32'(out),    32'(1));
    check("latency toggle", 32'(toggle), 32'(1));
    tick(1'b0, 1'b0, 3'b000, 12'h007, "post_rst3");
    check("toggle_pulse", 32'(toggle), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c_elem_sync_array.md
Name: c_elem_sync_array

Overview:
- Clocked, multi-channel successor to the asynchronous C-element.
- Each of CH_NUM channels takes IN_NUM inputs through a synchronizer and holds a phase bit. The phase sets when the set condition is met, clears when the clear condition is met, and holds otherwise.
- Adds the following over the asynchronous element:
  - symmetric mode and threshold (hysteresis) mode
  - input masking
  - one-cycle toggle pulses
  - a saturating event counter
  - per-channel stuck detection
- Sits between asynchronous handshake signals and synchronous control logic.

Parameters:
IN_NUM, 2, inputs per channel (>=1)
CH_NUM, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchronizer flops per input (>=1)
SET_TH, 2, threshold mode: phase sets when unmasked-ones count >= SET_TH
CLR_TH, 0, threshold mode: phase clears when unmasked-ones count <= CLR_TH; must be < SET_TH
CNT_W, 16, event counter width
TO_W, 8, stuck timer width
TIMEOUT, 255, consecutive hold cycles before stuck asserts (1..2^TO_W-1)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of phase, counter and timers
mode  in  1  0 = symmetric C, 1 = threshold
mask  in  IN_NUM  1 = input ignored, shared by all channels
in  in  CH_NUM*IN_NUM  channel c uses bits [c*IN_NUM +: IN_NUM]; may be asynchronous
out  out  CH_NUM  phase per channel
toggle  out  CH_NUM  one-cycle pulse on the cycle out[c] changes
evt_cnt  out  CNT_W  total toggles across all channels, saturating
stuck  out  CH_NUM  channel held while non-unanimous for TIMEOUT cycles

Behaviour:
- Reset (rst_n=0, asynchronous): clears all synchronizer flops, out, toggle, evt_cnt, stuck and timers to 0.
- Synchronizer: in passes through SYNC_STAGES flops per bit. Decision logic uses only the last stage.
- Latency: an input stable before rising edge k is reflected in out at edge k+SYNC_STAGES (SYNC_STAGES+1 edges counting k). toggle is high during the cycle after that edge.
- Per-channel conditions, using the unmasked inputs U and n = popcount(U=1):
  - Symmetric mode: set = all U are 1; clr_c = all U are 0.
  - Threshold mode: set = n >= SET_TH; clr_c = n <= CLR_TH.
  - If mask is all 1 (U empty): set = clr_c = 0 and the channel holds.
- Next phase:
  - phase=0 & set -> 1.
  - phase=1 & clr_c -> 0.
  - Otherwise phase holds, including a set condition while already 1.
- toggle[c] is registered: high exactly one cycle per phase change.
- evt_cnt: adds popcount(toggle-next) each cycle, so multiple simultaneous channel toggles add their count. Saturates at 2^CNT_W-1, no wrap.
- Stuck timer per channel:
  - Increments on a cycle where U is non-empty and neither set nor clr_c holds.
  - Otherwise resets to 0; a toggle also resets it.
  - Saturates at TIMEOUT.
  - stuck[c] = (timer == TIMEOUT), registered; drops the cycle after the condition ends.
- clr=1: next edge zeroes out, toggle, evt_cnt, timers and stuck. Synchronizers are unaffected. While clr is held, no phase updates occur.
- clr with a simultaneous set condition: clr wins.
- mode or mask change mid-operation: takes effect on the next edge's evaluation. Phase is not reset.
- Reset mid-operation: immediate asynchronous zeroing. After release, the first out change needs the full synchronizer latency.

Test Plan:
- Reset, symmetric mode, IN_NUM=2, ch0 in=2'b11 -> out[0]=1 at third edge, toggle[0] one cycle, evt_cnt=1. Then in=2'b01 -> out holds 1. Then in=2'b00 -> out[0]=0, evt_cnt=2.
- Threshold mode, IN_NUM=3, SET_TH=2, CLR_TH=0: in=3'b011 -> out=1. in=3'b001 -> hold 1. in=3'b000 -> out=0.
- mask=2'b10, ch0 in=2'b01 -> out[0]=1 (bit1 ignored). mask=2'b11 -> out holds regardless of in.
- Stuck, TIMEOUT=4: ch1 in=2'b10 held -> stuck[1] rises after 4 hold cycles. Then in=2'b11 -> out[1]=1, stuck[1] falls next cycle.
- All 4 channels toggle on the same edge -> evt_cnt +4. With CNT_W=2, starting at 2'b10 -> saturates at 2'b11.
- clr asserted alongside a pending set -> out stays 0 and evt_cnt=0. rst_n low mid-run -> all outputs 0 immediately, without a clock edge.
